uart_tx_periph: RTL

- Memory-mapped UART transmitter on the processor's data-memory bus, downstream of the load/store path. It consumes the same addr/wdata/wr_en/rd_en signals the data memory sees.
- Stores to TXDATA push bytes into a small FIFO. A baud-rate FSM serialises them 8N1 on tx.
- Loads return status and configuration combinationally, so single-cycle loads complete in the issuing cycle.

---
 rtl/uart_tx_periph_pkg.sv | 27 ++
 rtl/uart_tx_periph_if.sv | 12 +
 rtl/uart_tx_periph_sync_fifo.sv | 53 +++++
 rtl/uart_tx_periph.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_periph_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package uart_tx_periph_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic [3:0] UART_TXDATA = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;
  localparam logic [3:0] UART_BAUD   = 4'h8;
  localparam logic [3:0] UART_CTRL   = 4'hC;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_FULL   = 1;
  localparam int STAT_EMPTY  = 2;
  localparam int STAT_OVF    = 3;
  localparam int STAT_CNT_LO = 4;
  localparam int STAT_CNT_HI = 8;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_ODD    = 1;

endpackage

// File: rtl/uart_tx_periph_if.sv
// Data-memory bus as seen by the UART peripheral (processor = master).
interface uart_bus_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] rdata;
  logic        sel;

  modport master (output addr, wdata, wr_en, rd_en, input rdata, sel);
  modport slave  (input addr, wdata, wr_en, rd_en, output rdata, sel);
endinterface

// File: rtl/uart_tx_periph_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only when a pop happens at the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and combinational register reads.
// Optional parity frame bit is enabled by defining UART_PARITY_EN.
module uart_tx_periph
  import uart_tx_periph_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [15:0] DIV_RESET = 16'd868
) (
  input  logic       clk,
  input  logic       reset,
  uart_bus_if.slave  bus,
  output logic       tx,
  output logic       irq
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  function automatic logic [15:0] div_sat(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

  uart_state_t      state;
  uart_state_t      state_nxt;
  logic [3:0]       offset;
  logic             wr_hit;
  logic             push;
  logic             pop;
  logic             busy;
  logic [15:0]      baud_div;
  logic [15:0]      baud_cnt;
  logic [2:0]       bit_cnt;
  logic             bit_done;
  logic [7:0]       shift;
  logic             irq_en;
  logic             ovf;
  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [4:0]       count5;
  logic             unused_bits;
`ifdef UART_PARITY_EN
  logic             odd_par;
  logic             par;
`endif

  assign offset      = {bus.addr[3:2], 2'b00};
  assign bus.sel     = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign wr_hit      = bus.sel & bus.wr_en;
  assign push        = wr_hit && (offset == UART_TXDATA);
  assign bit_done    = (baud_cnt == 16'd0);
  assign count5      = 5'(fifo_count);
  assign irq         = fifo_empty && (state == IDLE) && irq_en;
  assign unused_bits = ^{bus.wdata[31:16], bus.addr[1:0]};

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (bus.wdata[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Register writes; a dropped push sets overflow, write-1 to STATUS[3] clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_div <= DIV_RESET;
      irq_en   <= 1'b0;
      ovf      <= 1'b0;
`ifdef UART_PARITY_EN
      odd_par  <= 1'b0;
`endif
    end else begin
      if (wr_hit && offset == UART_BAUD) baud_div <= div_sat(bus.wdata[15:0]);
      if (wr_hit && offset == UART_CTRL) begin
        irq_en  <= bus.wdata[CTRL_IRQ_EN];
`ifdef UART_PARITY_EN
        odd_par <= bus.wdata[CTRL_ODD];
`endif
      end
      if (push && fifo_full && !pop)
        ovf <= 1'b1;
      else if (wr_hit && offset == UART_STATUS && bus.wdata[STAT_OVF])
        ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!fifo_empty) state_nxt = START;
      START:  if (bit_done) state_nxt = DATA;
      DATA:   if (bit_done && bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                state_nxt = PARITY;
`else
                state_nxt = STOP;
`endif
              end
`ifdef UART_PARITY_EN
      PARITY: if (bit_done) state_nxt = STOP;
`endif
      STOP:   if (bit_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx   = 1'b1;
    pop  = 1'b0;
    busy = (state != IDLE);
    case (state)
      IDLE:   pop = !fifo_empty;
      START:  tx  = 1'b0;
      DATA:   tx  = shift[0];
`ifdef UART_PARITY_EN
      PARITY: tx  = par ^ odd_par;
`endif
      default: tx = 1'b1;
    endcase
  end

  // Baud/bit counters reload from the live BAUD_DIV at every bit boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_cnt <= 16'd0;
      bit_cnt  <= 3'd0;
    end else if (state == IDLE) begin
      if (pop) begin
        baud_cnt <= baud_div - 16'd1;
        bit_cnt  <= 3'd0;
      end
    end else if (bit_done) begin
      baud_cnt <= baud_div - 16'd1;
      if (state == DATA) bit_cnt <= bit_cnt + 3'd1;
    end else begin
      baud_cnt <= baud_cnt - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && pop) begin
      shift <= fifo_dout;
`ifdef UART_PARITY_EN
      par   <= ^fifo_dout;
`endif
    end else if (state == DATA && bit_done) begin
      shift <= {1'b0, shift[7:1]};
    end
  end

  always_comb begin
    bus.rdata = 32'd0;
    if (bus.sel && bus.rd_en) begin
      case (offset)
        UART_STATUS: begin
          bus.rdata[STAT_BUSY]               = busy;
          bus.rdata[STAT_FULL]               = fifo_full;
          bus.rdata[STAT_EMPTY]              = fifo_empty;
          bus.rdata[STAT_OVF]                = ovf;
          bus.rdata[STAT_CNT_HI:STAT_CNT_LO] = count5;
        end
        UART_BAUD: bus.rdata[15:0] = baud_div;
        UART_CTRL: begin
          bus.rdata[CTRL_IRQ_EN] = irq_en;
`ifdef UART_PARITY_EN
          bus.rdata[CTRL_ODD]    = odd_par;
`endif
        end
        default: bus.rdata = 32'd0;
      endcase
    end
  end

endmodule
